l1_bus_responder: RTL and testbench
===================================

Name: l1_bus_responder

Overview:
- Bus-side reader for the 4-entry L1 cache's data/address/status read port.
- Accepts lookup requests from the shared bus and drives the L1 line-select to scan the entries one per cycle.
- Compares each entry's stored address and status against the request and returns data, status and a hit flag over a valid/ready response channel.
- Sits between the L1 read port and the L2/bus arbiter; it is the consumer end of the L1 dOut/addrOut/statusOut interface.

Parameters:
- DATA_W, 8, width of a cache data word
- ADDR_W, 3, width of a bus/L1 tag address
- STAT_W, 2, width of an L1 status field
- ENTRIES, 4, number of L1 lines scanned; power of two; select width is $clog2(ENTRIES)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  bus lookup request valid
- req_ready  out  1  responder can accept a request
- req_addr  in  ADDR_W  address to look up
- l1_sel  out  $clog2(ENTRIES)  line select driven to the L1 read port
- l1_data  in  DATA_W  L1 data of selected line (combinational from l1_sel)
- l1_addr  in  ADDR_W  L1 stored address of selected line
- l1_status  in  STAT_W  L1 status of selected line
- resp_valid  out  1  response valid
- resp_ready  in  1  bus accepts response
- resp_hit  out  1  1 = address found in a valid line
- resp_data  out  DATA_W  data of hit line, 0 on miss
- resp_status  out  STAT_W  status of hit line, 0 on miss
- resp_line  out  $clog2(ENTRIES)  index of hit line, 0 on miss

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; resp_valid=0; resp_hit=0; resp_data=0; resp_status=0; resp_line=0; l1_sel=0; scan index 0; latched address 0.
- Line validity: a line is valid iff l1_status != 0. Status 0 (power-up, or status wrapped to 0) is a miss even when l1_addr matches. This prevents false hits on reset-initialised lines holding address 0.
- FSM states: IDLE, SCAN, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at edge E0: latch req_addr, set index=0, go to SCAN.
- SCAN:
  - req_ready=0; l1_sel=index.
  - Each cycle, compare l1_addr against the latched address, qualified by validity, combinationally.
  - On a hit at the next edge: register l1_data/l1_status/index into resp_*, set resp_hit=1, go to RESP.
  - Else, if index==ENTRIES-1: register a miss (resp_hit=0, data/status/line=0), go to RESP.
  - Else: index+1.
  - The first (lowest-index) hit wins.
- Latency: a hit at line k gives resp_valid=1 after edge E(k+1). A miss gives resp_valid=1 after edge E(ENTRIES).
- RESP:
  - resp_valid=1. All resp_* are held stable until resp_valid&&resp_ready.
  - On that handshake edge: resp_valid=0, go to IDLE.
  - req_ready=0 throughout RESP, so the next request is accepted no earlier than the cycle after the handshake.
  - Consequence: back-to-back throughput is 1 lookup per (k+3) cycles minimum.
- l1_sel is held at 0 in IDLE and RESP.
- req_valid deasserted mid-scan: ignored; the lookup completes with the latched address.
- An L1 write during SCAN is not made coherent; each line's result reflects the value sampled in that line's scan cycle.
- Reset mid-SCAN or mid-RESP: immediate abort to IDLE, response dropped, outputs return to reset values.

Optional Feature:
- Macro: L1_RESP_HIT_CNT_EN
- With the macro defined:
  - Adds outputs hit_count[7:0] and miss_count[7:0].
  - Each increments by 1 at the edge entering RESP with the matching outcome.
  - Both saturate at 8'hFF and are cleared by rst_n.
- Without the macro: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package l1_bus_pkg holds:
  - the state enum (IDLE/SCAN/RESP)
  - DATA_W/ADDR_W/STAT_W defaults
  - the STAT_INVALID=0 constant
  - the line-select width function
- One natural sub-module: l1_line_match, the combinational compare of l1_addr/l1_status against the latched address, producing hit.
- FSM, index counter and response registers stay in the top.

Test Plan:
- L1 empty (all status 0, addr 0); request addr 3'b000 -> miss, resp_valid after E4, resp_hit=0, resp_data=8'h00.
- Line0={data AA, addr 001, status 01}; request 001 -> resp_valid after E1, hit=1, data=AA, status=01, line=0.
- Line0={AA,001,01}, line1={55,011,01}, line2={0F,111,01}; request 111 -> resp_valid after E3, data=0F, line=2. Request 010 -> miss after E4.
- Hold resp_ready=0 for 5 cycles after a hit -> resp_* unchanged, req_ready=0; a req_valid pulse during RESP is not accepted; resp_ready=1 -> IDLE next cycle.
- Assert rst_n=0 during SCAN at index 2 -> state IDLE, resp_valid=0, l1_sel=0 immediately; a new request after release completes normally.
- With L1_RESP_HIT_CNT_EN: 3 hits + 2 misses -> hit_count=3, miss_count=2. 300 hits -> hit_count=8'hFF.

Source files
------------

// File: rtl/l1_bus_pkg.sv
// Shared types and constants for the L1 bus-side lookup responder.
package l1_bus_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 3;
   localparam int STAT_W_DEF = 2;

   // A status of zero marks an empty or wrapped line; it never hits.
   localparam int STAT_INVALID = 0;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   function automatic int sel_width(input int entries);
      return (entries <= 1) ? 1 : $clog2(entries);
   endfunction
endpackage

// File: rtl/l1_line_match.sv
// Combinational compare of the selected L1 line against the latched lookup address.
module l1_line_match
   import l1_bus_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int STAT_W = STAT_W_DEF
) (
   input  logic [ADDR_W-1:0] line_addr,
   input  logic [STAT_W-1:0] line_status,
   input  logic [ADDR_W-1:0] match_addr,
   output logic              hit
);
   assign hit = (line_status != STAT_W'(STAT_INVALID)) && (line_addr == match_addr);
endmodule

// File: rtl/l1_bus_responder.sv
// Bus-side reader scanning the L1 lines one per cycle and returning the first valid hit.
// Optional hit/miss counters are built when L1_RESP_HIT_CNT_EN is defined.
module l1_bus_responder
   import l1_bus_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int STAT_W  = STAT_W_DEF,
   parameter int ENTRIES = 4,
   localparam int SEL_W  = sel_width(ENTRIES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic [SEL_W-1:0]  l1_sel,
   input  logic [DATA_W-1:0] l1_data,
   input  logic [ADDR_W-1:0] l1_addr,
   input  logic [STAT_W-1:0] l1_status,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_hit,
   output logic [DATA_W-1:0] resp_data,
   output logic [STAT_W-1:0] resp_status,
`ifdef L1_RESP_HIT_CNT_EN
   output logic [7:0]        hit_count,
   output logic [7:0]        miss_count,
`endif
   output logic [SEL_W-1:0]  resp_line
);
   logic [1:0]        state;
   logic [SEL_W-1:0]  idx;
   logic [ADDR_W-1:0] addr_q;
   logic              hit;
   logic              last;

   l1_line_match #(.ADDR_W(ADDR_W), .STAT_W(STAT_W)) u_match (
      .line_addr   (l1_addr),
      .line_status (l1_status),
      .match_addr  (addr_q),
      .hit         (hit)
   );

   assign last       = (idx == SEL_W'(ENTRIES - 1));
   assign req_ready  = (state == ST_IDLE);
   assign resp_valid = (state == ST_RESP);
   assign l1_sel     = (state == ST_SCAN) ? idx : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         idx         <= '0;
         addr_q      <= '0;
         resp_hit    <= 1'b0;
         resp_data   <= '0;
         resp_status <= '0;
         resp_line   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  addr_q <= req_addr;
                  idx    <= '0;
                  state  <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (hit) begin
                  resp_hit    <= 1'b1;
                  resp_data   <= l1_data;
                  resp_status <= l1_status;
                  resp_line   <= idx;
                  state       <= ST_RESP;
               end else if (last) begin
                  resp_hit    <= 1'b0;
                  resp_data   <= '0;
                  resp_status <= '0;
                  resp_line   <= '0;
                  state       <= ST_RESP;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_RESP: begin
               if (resp_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef L1_RESP_HIT_CNT_EN
   // Counts step on the edge that enters RESP and stick at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state == ST_SCAN) begin
         if (hit) begin
            if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
         end else if (last) begin
            if (miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_l1_bus_responder.sv
// Scoreboard bench for l1_bus_responder with a behavioural 4-line L1 model.
module tb_l1_bus_responder;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [2:0] req_addr = '0;
   logic [1:0] l1_sel;
   logic [7:0] l1_data;
   logic [2:0] l1_addr;
   logic [1:0] l1_status;
   logic       resp_valid;
   logic       resp_ready = 1'b0;
   logic       resp_hit;
   logic [7:0] resp_data;
   logic [1:0] resp_status;
   logic [1:0] resp_line;
`ifdef L1_RESP_HIT_CNT_EN
   logic [7:0] hit_count, miss_count;
`endif

   logic [7:0] mem_data [4];
   logic [2:0] mem_addr [4];
   logic [1:0] mem_stat [4];

   typedef struct {
      logic       hit;
      logic [7:0] data;
      logic [1:0] st;
      logic [1:0] line;
      int         lat;
   } exp_t;
   exp_t sb[$];
   exp_t e;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign l1_data   = mem_data[l1_sel];
   assign l1_addr   = mem_addr[l1_sel];
   assign l1_status = mem_stat[l1_sel];

   l1_bus_responder dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .l1_sel(l1_sel), .l1_data(l1_data), .l1_addr(l1_addr), .l1_status(l1_status),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_hit(resp_hit), .resp_data(resp_data), .resp_status(resp_status),
`ifdef L1_RESP_HIT_CNT_EN
      .hit_count(hit_count), .miss_count(miss_count),
`endif
      .resp_line(resp_line)
   );

   task automatic set_line(input int i, input logic [7:0] d, input logic [2:0] a, input logic [1:0] s);
      mem_data[i] = d; mem_addr[i] = a; mem_stat[i] = s;
   endtask

   // Drives one request and pushes the model's expectation; returns just after E0.
   task automatic issue(input logic [2:0] a);
      exp_t x;
      x = '{hit: 1'b0, data: 8'h00, st: 2'b00, line: 2'd0, lat: 4};
      for (int i = 0; i < 4; i++)
         if (!x.hit && mem_stat[i] != 2'b00 && mem_addr[i] == a)
            x = '{hit: 1'b1, data: mem_data[i], st: mem_stat[i], line: 2'(i), lat: i + 1};
      sb.push_back(x);
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = a;
      @(posedge clk);
   endtask

   task automatic wait_resp(output int cyc);
      cyc = 0;
      @(negedge clk);
      req_valid = 1'b0;
      while (!resp_valid && cyc < 20) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic ack();
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   task automatic lookup(input logic [2:0] a);
      int cyc;
      issue(a);
      wait_resp(cyc);
      void'(sb.pop_front());
      ack();
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({req_ready, resp_valid, resp_hit, resp_data, resp_status, resp_line, l1_sel} !== {1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 2'd0, 2'd0}) begin
         errors++;
         $display("FAIL reset_outputs got rr=%b rv=%b hit=%b d=%h s=%b ln=%0d sel=%0d", req_ready, resp_valid, resp_hit, resp_data, resp_status, resp_line, l1_sel);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_lookup(input string name, input logic [2:0] a);
      int cyc;
      issue(a);
      wait_resp(cyc);
      e = sb.pop_front();
      checks++;
      if (cyc !== e.lat) begin
         errors++;
         $display("FAIL %s_latency got %0d want %0d", name, cyc, e.lat);
      end
      checks++;
      if ({resp_valid, resp_hit, resp_data, resp_status, resp_line} !== {1'b1, e.hit, e.data, e.st, e.line}) begin
         errors++;
         $display("FAIL %s_resp got v=%b hit=%b d=%h s=%b ln=%0d want hit=%b d=%h s=%b ln=%0d", name, resp_valid, resp_hit, resp_data, resp_status, resp_line, e.hit, e.data, e.st, e.line);
      end
      ack();
      checks++;
      if ({req_ready, resp_valid} !== 2'b10) begin
         errors++;
         $display("FAIL %s_idle got rr=%b rv=%b want rr=1 rv=0", name, req_ready, resp_valid);
      end
   endtask

   task automatic test_hold();
      int cyc;
      issue(3'b011);
      wait_resp(cyc);
      e = sb.pop_front();
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin req_valid = 1'b1; req_addr = 3'b001; end
         else req_valid = 1'b0;
         checks++;
         if ({resp_valid, req_ready, resp_hit, resp_data, resp_status, resp_line} !== {1'b1, 1'b0, e.hit, e.data, e.st, e.line}) begin
            errors++;
            $display("FAIL hold_cycle%0d got v=%b rr=%b hit=%b d=%h ln=%0d want d=%h ln=%0d", c, resp_valid, req_ready, resp_hit, resp_data, resp_line, e.data, e.line);
         end
         @(posedge clk);
         @(negedge clk);
      end
      req_valid = 1'b0;
      ack();
      for (int c = 0; c < 2; c++) begin
         checks++;
         if ({req_ready, resp_valid, l1_sel} !== {1'b1, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL hold_after_ack%0d got rr=%b rv=%b sel=%0d want rr=1 rv=0 sel=0", c, req_ready, resp_valid, l1_sel);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_scan();
      issue(3'b100);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      checks++;
      if (l1_sel !== 2'd2) begin
         errors++;
         $display("FAIL midscan_sel got %0d want 2", l1_sel);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({req_ready, resp_valid, l1_sel, resp_hit, resp_data} !== {1'b1, 1'b0, 2'd0, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL midscan_abort got rr=%b rv=%b sel=%0d hit=%b d=%h want rr=1 rv=0 sel=0", req_ready, resp_valid, l1_sel, resp_hit, resp_data);
      end
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      test_lookup("post_reset", 3'b111);
   endtask

`ifdef L1_RESP_HIT_CNT_EN
   task automatic test_counters();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      lookup(3'b001); lookup(3'b011); lookup(3'b111);
      lookup(3'b010); lookup(3'b100);
      checks++;
      if ({hit_count, miss_count} !== {8'd3, 8'd2}) begin
         errors++;
         $display("FAIL counts got hit=%0d miss=%0d want 3 2", hit_count, miss_count);
      end
      for (int i = 0; i < 300; i++) lookup(3'b001);
      checks++;
      if ({hit_count, miss_count} !== {8'hFF, 8'd2}) begin
         errors++;
         $display("FAIL count_sat got hit=%h miss=%0d want ff 2", hit_count, miss_count);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 4; i++) set_line(i, 8'h00, 3'b000, 2'b00);
      test_reset();
      test_lookup("empty_miss", 3'b000);
      set_line(0, 8'hAA, 3'b001, 2'b01);
      test_lookup("line0_hit", 3'b001);
      set_line(1, 8'h55, 3'b011, 2'b01);
      set_line(2, 8'h0F, 3'b111, 2'b01);
      test_lookup("line2_hit", 3'b111);
      test_lookup("miss_010", 3'b010);
      test_lookup("line1_hit", 3'b011);
      set_line(3, 8'hCC, 3'b010, 2'b00);
      test_lookup("invalid_line_miss", 3'b010);
      set_line(3, 8'h99, 3'b111, 2'b11);
      test_lookup("lowest_wins", 3'b111);
      set_line(3, 8'hC3, 3'b110, 2'b10);
      test_lookup("line3_hit", 3'b110);
      test_hold();
      test_reset_mid_scan();
`ifdef L1_RESP_HIT_CNT_EN
      test_counters();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
